rv_voter_scheduler: RTL

- Time-shares one RootVoter cell between NUM_REQ requesters (core groups or software channels).
- Arbitrates requests round-robin and drives the cell's cfg word for the granted requester.
- Waits for the cell's ready flag, captures its 40-bit status, then writes cfg[7:0]=0 and waits for the cell to return to idle.
- A watchdog aborts and resets the cell if a vote never completes.

---
 rtl/rv_voter_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rv_voter_scheduler.sv
// Round-robin scheduler time-sharing one RootVoter cell between NUM_REQ requesters.
// Checks cfg legality, runs the vote under a watchdog, captures status and releases the cell.
module rv_voter_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CFG_WIDTH    = 64,
  parameter int MAX_DATASETS = 9,
  parameter int WDOG_CYCLES  = 65536
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CFG_WIDTH-1:0] req_cfg,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [NUM_REQ-1:0]           err,
  output logic [39:0]                  result,
  output logic                         busy,
  output logic [CFG_WIDTH-1:0]         rvc_cfg,
  output logic                         rvc_reset,
  input  logic [39:0]                  rvc_status,
  input  logic [4:0]                   rvc_state
);

  localparam int          IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          WW    = $clog2(WDOG_CYCLES + 1);
  localparam int unsigned NR    = NUM_REQ;
  localparam logic [3:0]  MAX_U = 4'(MAX_DATASETS);

  typedef enum logic [2:0] {IDLE, CHECK, RUN, CAPTURE, ABORT, RELEASE} state_t;

  state_t                 state, state_d;
  logic [IW-1:0]          idx_q, idx_d, rr_ptr, rr_d, win;
  logic [CFG_WIDTH-1:0]   cfg_l, cfg_d, rvc_cfg_d;
  logic [WW-1:0]          wdog, wdog_d;
  logic [NUM_REQ-1:0]     grant_d, done_d, err_d;
  logic [39:0]            result_d;
  logic                   busy_d, rvc_reset_d, found, legal;
  logic [CFG_WIDTH-1:0]   cfg_arr [NUM_REQ];
  int unsigned            pos;
  logic                   unused_state_bits;

  assign unused_state_bits = ^rvc_state[4:1];

  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      cfg_arr[i] = req_cfg[i*CFG_WIDTH +: CFG_WIDTH];
    end
  end

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = 0;
    for (int unsigned off = 0; off < NR; off++) begin
      pos = 32'(rr_ptr) + off;
      if (pos >= NR) pos = pos - NR;
      if (!found && req[IW'(pos)]) begin
        found = 1'b1;
        win   = IW'(pos);
      end
    end
  end

  assign legal = (cfg_l[3:0] >= 4'd2) && (cfg_l[3:0] <= MAX_U) && (cfg_l[7:4] <= cfg_l[3:0]);

  always_comb begin
    state_d     = state;
    idx_d       = idx_q;
    rr_d        = rr_ptr;
    cfg_d       = cfg_l;
    wdog_d      = wdog;
    grant_d     = grant;
    done_d      = '0;
    err_d       = '0;
    result_d    = result;
    rvc_cfg_d   = rvc_cfg;
    rvc_reset_d = 1'b0;
    case (state)
      IDLE: begin
        rvc_cfg_d = '0;
        if (found) begin
          idx_d        = win;
          cfg_d        = cfg_arr[win];
          grant_d      = '0;
          grant_d[win] = 1'b1;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        if (legal) begin
          rvc_cfg_d = cfg_l;
          wdog_d    = WW'(WDOG_CYCLES);
          state_d   = RUN;
        end else begin
          done_d[idx_q] = 1'b1;
          err_d[idx_q]  = 1'b1;
          result_d      = '0;
          grant_d       = '0;
          state_d       = RELEASE;
        end
      end
      RUN: begin
        rvc_cfg_d = cfg_l;
        wdog_d    = wdog - WW'(1);
        if (rvc_status[0]) begin
          state_d = CAPTURE;
        end else if (wdog == WW'(1)) begin
          // Cell reset is raised on entry so it is visible for the whole ABORT cycle.
          rvc_reset_d = 1'b1;
          state_d     = ABORT;
        end
      end
      CAPTURE: begin
        result_d      = rvc_status;
        done_d[idx_q] = 1'b1;
        grant_d       = '0;
        rvc_cfg_d     = '0;
        state_d       = RELEASE;
      end
      ABORT: begin
        rvc_cfg_d     = '0;
        result_d      = '0;
        done_d[idx_q] = 1'b1;
        err_d[idx_q]  = 1'b1;
        grant_d       = '0;
        state_d       = RELEASE;
      end
      RELEASE: begin
        rvc_cfg_d = '0;
        if (rvc_state[0]) begin
          rr_d    = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx_q     <= '0;
      rr_ptr    <= '0;
      cfg_l     <= '0;
      wdog      <= '0;
      grant     <= '0;
      done      <= '0;
      err       <= '0;
      result    <= '0;
      busy      <= 1'b0;
      rvc_cfg   <= '0;
      rvc_reset <= 1'b0;
    end else begin
      state     <= state_d;
      idx_q     <= idx_d;
      rr_ptr    <= rr_d;
      cfg_l     <= cfg_d;
      wdog      <= wdog_d;
      grant     <= grant_d;
      done      <= done_d;
      err       <= err_d;
      result    <= result_d;
      busy      <= busy_d;
      rvc_cfg   <= rvc_cfg_d;
      rvc_reset <= rvc_reset_d;
    end
  end

endmodule
